// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_pkg: shared types and constants for the product BCD converter     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int BIN_W_DEF  = 8;
  localparam int DIGITS_DEF = 3;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_pattern = SEG7_0;
      4'd1:    seg7_pattern = SEG7_1;
      4'd2:    seg7_pattern = SEG7_2;
      4'd3:    seg7_pattern = SEG7_3;
      4'd4:    seg7_pattern = SEG7_4;
      4'd5:    seg7_pattern = SEG7_5;
      4'd6:    seg7_pattern = SEG7_6;
      4'd7:    seg7_pattern = SEG7_7;
      4'd8:    seg7_pattern = SEG7_8;
      4'd9:    seg7_pattern = SEG7_9;
      default: seg7_pattern = SEG7_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_seg7: one BCD digit to active-low seven-segment pattern;       |
// | values above 9 show blank.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg7_pattern(digit);

endmodule
`default_nettype wire

// File: rtl/product_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | product_bcd_converter: sequential shift-and-add-3 binary to BCD       |
// | converter; optional seven-segment outputs behind BCD_SEG7_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module product_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_i,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             valid,
  output logic             busy,
  output logic [3:0]       state
`ifdef BCD_SEG7_EN
  ,
  output logic [6:0]       seg_hundreds,
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_ones
`endif
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  bcd_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_scratch;
  logic [BIN_W-1:0]   r_bin;
  logic [3:0]         r_hundreds;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic               r_valid;
  logic [SCR_W-1:0]   w_adj;

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= BCD_ADJ_THRESH)
                            ? r_scratch[gi*4 +: 4] + BCD_ADJ_VAL
                            : r_scratch[gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_scratch  <= '0;
      r_bin      <= '0;
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin     <= bin_i;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust first, then shift the combined register by one bit
          {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) r_state <= DONE;
        end
        DONE: begin
          r_hundreds <= r_scratch[8 +: 4];
          r_tens     <= r_scratch[4 +: 4];
          r_ones     <= r_scratch[0 +: 4];
          r_valid    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bcd_hundreds = r_hundreds;
  assign bcd_tens     = r_tens;
  assign bcd_ones     = r_ones;
  assign valid        = r_valid;
  assign busy         = (r_state != IDLE);
  assign state        = {2'b00, r_state};

`ifdef BCD_SEG7_EN
  bcd_to_seg7 u_seg_hundreds (.digit(r_hundreds), .seg(seg_hundreds));
  bcd_to_seg7 u_seg_tens     (.digit(r_tens),     .seg(seg_tens));
  bcd_to_seg7 u_seg_ones     (.digit(r_ones),     .seg(seg_ones));
`endif

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_product_bcd_converter: directed self-checking bench for the        |
// | product BCD converter (seg checks compile in with BCD_SEG7_EN).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_product_bcd_converter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] bin_i;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       valid;
  logic       busy;
  logic [3:0] state;
`ifdef BCD_SEG7_EN
  logic [6:0] seg_hundreds;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_valid = 0;

  product_bcd_converter #(.BIN_W(8), .DIGITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bin_i        (bin_i),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .valid        (valid),
    .busy         (busy),
    .state        (state)
`ifdef BCD_SEG7_EN
    ,
    .seg_hundreds (seg_hundreds),
    .seg_tens     (seg_tens),
    .seg_ones     (seg_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (valid === 1'b1) n_valid++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    case (d)
      4'd0: seg_exp = 7'b1000000;  4'd1: seg_exp = 7'b1111001;
      4'd2: seg_exp = 7'b0100100;  4'd3: seg_exp = 7'b0110000;
      4'd4: seg_exp = 7'b0011001;  4'd5: seg_exp = 7'b0010010;
      4'd6: seg_exp = 7'b0000010;  4'd7: seg_exp = 7'b1111000;
      4'd8: seg_exp = 7'b0000000;  4'd9: seg_exp = 7'b0010000;
      default: seg_exp = 7'b1111111;
    endcase
  endfunction

  task automatic check_digits(input string tag, input logic [3:0] eh, input logic [3:0] et,
                              input logic [3:0] eo);
    check({tag, "_hundreds"}, 32'(bcd_hundreds), 32'(eh));
    check({tag, "_tens"},     32'(bcd_tens),     32'(et));
    check({tag, "_ones"},     32'(bcd_ones),     32'(eo));
`ifdef BCD_SEG7_EN
    check({tag, "_seg_h"}, 32'(seg_hundreds), 32'(seg_exp(eh)));
    check({tag, "_seg_t"}, 32'(seg_tens),     32'(seg_exp(et)));
    check({tag, "_seg_o"}, 32'(seg_ones),     32'(seg_exp(eo)));
`endif
  endtask

  // Single start pulse at edge k; optional ignored start presented at edge k+3
  task automatic convert(input string tag, input logic [7:0] v, input logic [3:0] eh,
                         input logic [3:0] et, input logic [3:0] eo, input bit poke);
    int v0;
    @(negedge clk); start = 1'b1; bin_i = v;
    @(posedge clk); #1;
    v0 = n_valid;
    check({tag, "_busy_k"}, 32'(busy), 32'd1);
    @(negedge clk); start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (poke && e == 3) begin start = 1'b1; bin_i = 8'd9; end
      @(posedge clk); #1;
      if (poke && e == 3) begin
        start = 1'b0;
        check({tag, "_ignored_state"}, 32'(state), 32'd1);
      end
    end
    check({tag, "_state_k8"}, 32'(state), 32'd2);
    check({tag, "_valid_k8"}, 32'(valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_k9"}, 32'(valid), 32'd1);
    check_digits(tag, eh, et, eo);
    @(posedge clk); #1;
    check({tag, "_valid_k10"}, 32'(valid), 32'd0);
    check({tag, "_state_k10"}, 32'(state), 32'd0);
    check({tag, "_pulses"}, 32'(n_valid - v0), 32'd1);
  endtask

  initial begin
    int v0;
    rst = 1'b0; start = 1'b0; bin_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_state", 32'(state), 32'd0);
    check_digits("reset", 4'd0, 4'd0, 4'd0);
    @(negedge clk); rst = 1'b1;

    convert("c225", 8'd225, 4'd2, 4'd2, 4'd5, 1'b0);
    convert("c0",   8'd0,   4'd0, 4'd0, 4'd0, 1'b0);
    convert("c255", 8'd255, 4'd2, 4'd5, 4'd5, 1'b0);
    convert("c7",   8'd7,   4'd0, 4'd0, 4'd7, 1'b0);
    convert("ign",  8'd225, 4'd2, 4'd2, 4'd5, 1'b1);
    convert("c7b",  8'd7,   4'd0, 4'd0, 4'd7, 1'b0);

    // Asynchronous reset during the fourth shift
    @(negedge clk); start = 1'b1; bin_i = 8'd225;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ones",  32'(bcd_ones), 32'd0);
    check("rst_mid_busy",  32'(busy),     32'd0);
    check("rst_mid_state", 32'(state),    32'd0);
    check("rst_mid_valid", 32'(valid),    32'd0);
    v0 = n_valid;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_pulse", 32'(n_valid - v0), 32'd0);
    check("rst_idle",     32'(state),        32'd0);
    convert("c42", 8'd42, 4'd0, 4'd4, 4'd2, 1'b0);

    // Start held high: retrigger every 10 cycles, bin_i sampled only on accept
    @(negedge clk); start = 1'b1; bin_i = 8'd100;
    @(posedge clk); #1;
    check("b2b_busy_k", 32'(busy), 32'd1);
    @(negedge clk); bin_i = 8'd99;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_valid_k8", 32'(valid), 32'd0);
    @(posedge clk); #1;
    check("b2b1_valid", 32'(valid), 32'd1);
    check_digits("b2b1", 4'd1, 4'd0, 4'd0);
    @(posedge clk); #1;
    check("b2b_retrig_state", 32'(state), 32'd1);
    check("b2b_retrig_valid", 32'(valid), 32'd0);
    repeat (9) @(posedge clk);
    #1;
    check("b2b2_valid", 32'(valid), 32'd1);
    check_digits("b2b2", 4'd0, 4'd9, 4'd9);
    @(negedge clk); start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("final_idle", 32'(state), 32'd0);
    check_digits("final_hold", 4'd0, 4'd9, 4'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
